ro_meter_multich: RTL and testbench

- Parametrised successor to the single-pair ring-oscillator counter path.
- Selects one of CHANNELS pre-divided oscillator inputs and enables only that oscillator.
- Counts its rising edges over a fixed clk1 gate window, repeating 2^LOG2_AVG times, then reports the batch sum and average.
- Sits between the oscillator bank and the FSM controller / UART byte mux; start/busy/done handshake.

---
 rtl/ro_meter_multich.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ro_meter_multich.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_meter_multich.sv
// ro_meter_multich
// Multichannel ring-oscillator frequency meter. One of CHANNELS pre-divided
// oscillator inputs is selected and enabled for a batch. After a warm-up
// period, the meter counts the oscillator's rising edges over 2^LOG2_AVG
// fixed gate windows of WINDOW clk1 cycles each. It then reports the batch
// sum and the truncated average through a start/busy/done handshake.
//
// Build option: define ROMETER_MINMAX_EN to track the smallest and largest
// window count of each batch on min_out/max_out. Without the macro, both
// outputs are tied to zero and no tracking logic is built.

module ro_meter_multich #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int WARMUP      = 16,
  parameter int LOG2_AVG    = 3,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SUM_W = CNT_W + LOG2_AVG
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] osc_in,
  output logic [CHANNELS-1:0] osc_en,
  input  logic                start,
  input  logic                abort,
  input  logic [CH_W-1:0]     ch_sel,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ovf,
  output logic [CH_W-1:0]     result_ch,
  output logic [SUM_W-1:0]    sum_out,
  output logic [CNT_W-1:0]    avg_out,
  output logic [CNT_W-1:0]    min_out,
  output logic [CNT_W-1:0]    max_out
);

  // The timer must be wide enough for the longer of the warm-up and gate periods.
  localparam int TMR_MAX = (WARMUP > WINDOW) ? WARMUP : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int IDX_W   = LOG2_AVG + 1;

  localparam logic [TMR_W-1:0] WARM_LOAD = TMR_W'(WARMUP - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'((1 << LOG2_AVG) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WARM  = 3'd1,
    S_GATE  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [TMR_W-1:0]    tmr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [SUM_W-1:0]    acc_reg;
  logic [SUM_W-1:0]    acc_sum;
  logic [IDX_W-1:0]    idx_reg;
  logic [CH_W-1:0]     ch_reg;
  logic                batch_ovf_reg;
  logic                prev_reg;
  logic                sample;
  logic                rise;
  logic                ch_ok;
  logic                last_sample;
  logic [CHANNELS-1:0] synced;
  logic [CHANNELS-1:0] ch_onehot;

  logic [SUM_W-1:0]    sum_reg;
  logic                ovf_reg;
  logic                err_reg;
  logic [CH_W-1:0]     result_ch_reg;

  // A channel number equal to or above CHANNELS is rejected with err.
  assign ch_ok       = ({1'b0, ch_sel} < CH_LIMIT);
  assign last_sample = (idx_reg == IDX_LAST);
  assign acc_sum     = acc_reg + SUM_W'(cnt_reg);

  // One synchroniser chain per channel. All chains run continuously, so
  // the selected one is already settled when the warm-up ends.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift the asynchronous oscillator level into clk1.
      always_ff @(posedge clk1) begin
        if (!rst_n) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], osc_in[gi]};
        end
      end

      assign synced[gi]    = chain_reg[SYNC_STAGES-1];
      assign ch_onehot[gi] = (ch_reg == CH_W'(gi));
    end
  endgenerate

  assign sample = synced[ch_reg];
  assign rise   = sample & ~prev_reg;

  // State register.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. abort only cancels an active measurement, and start
  // has priority over abort in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = ch_ok ? S_WARM : S_DONE;
        end
      end
      S_WARM: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (tmr_reg == '0) begin
          state_next = S_GATE;
        end
      end
      S_GATE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (tmr_reg == '0) begin
          state_next = S_STORE;
        end
      end
      S_STORE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (last_sample) begin
          state_next = S_DONE;
        end else begin
          state_next = S_GATE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs. The oscillator is enabled only while a measurement is in progress.
  always_comb begin
    busy   = 1'b1;
    done   = 1'b0;
    osc_en = '0;
    case (state_reg)
      S_IDLE:                  busy   = 1'b0;
      S_WARM, S_GATE, S_STORE: osc_en = ch_onehot;
      S_DONE:                  done   = 1'b1;
      default:                 busy   = 1'b0;
    endcase
  end

  // Gate timer, window edge counter, accumulator and per-batch bookkeeping.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      tmr_reg       <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      idx_reg       <= '0;
      ch_reg        <= '0;
      batch_ovf_reg <= 1'b0;
      prev_reg      <= 1'b0;
    end else begin
      // prev_reg follows the sample in every state. This prevents a level
      // that was already high at the start of a gate from counting as an edge.
      prev_reg <= sample;

      // The timer reloads on every state change and counts down to zero otherwise.
      if (state_next != state_reg) begin
        if (state_next == S_WARM) begin
          tmr_reg <= WARM_LOAD;
        end else begin
          tmr_reg <= GATE_LOAD;
        end
      end else if (tmr_reg != '0) begin
        tmr_reg <= tmr_reg - 1'b1;
      end

      if ((state_reg == S_IDLE) && (state_next == S_WARM)) begin
        ch_reg        <= ch_sel;
        acc_reg       <= '0;
        idx_reg       <= '0;
        batch_ovf_reg <= 1'b0;
      end

      // Edges are counted only inside the gate. The counter is zero everywhere else.
      if (state_reg == S_GATE) begin
        if (rise) begin
          if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (cnt_reg >= (CNT_MAX - 1'b1)) begin
            batch_ovf_reg <= 1'b1;
          end
        end
      end else begin
        cnt_reg <= '0;
      end

      if (state_reg == S_STORE) begin
        acc_reg <= acc_sum;
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Results change only on entry to DONE. They hold across aborts and rejected starts.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      result_ch_reg <= '0;
    end else if ((state_reg == S_STORE) && (state_next == S_DONE)) begin
      sum_reg       <= acc_sum;
      ovf_reg       <= batch_ovf_reg;
      err_reg       <= 1'b0;
      result_ch_reg <= ch_reg;
    end else if ((state_reg == S_IDLE) && (state_next == S_DONE)) begin
      err_reg <= 1'b1;
    end
  end

  assign err       = done & err_reg;
  assign ovf       = ovf_reg;
  assign result_ch = result_ch_reg;
  assign sum_out   = sum_reg;
  assign avg_out   = sum_reg[SUM_W-1:LOG2_AVG];

`ifdef ROMETER_MINMAX_EN
  logic [CNT_W-1:0] min_run_reg, max_run_reg;
  logic [CNT_W-1:0] min_new, max_new;
  logic [CNT_W-1:0] min_reg, max_reg;

  // The first window of a batch seeds both extremes. Later windows refine them.
  always_comb begin
    min_new = cnt_reg;
    max_new = cnt_reg;
    if (idx_reg != '0) begin
      if (min_run_reg < cnt_reg) begin
        min_new = min_run_reg;
      end
      if (max_run_reg > cnt_reg) begin
        max_new = max_run_reg;
      end
    end
  end

  // Track the extremes at each STORE and publish them together with the sum.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      min_run_reg <= '0;
      max_run_reg <= '0;
      min_reg     <= '0;
      max_reg     <= '0;
    end else if (state_reg == S_STORE) begin
      min_run_reg <= min_new;
      max_run_reg <= max_new;
      if (state_next == S_DONE) begin
        min_reg <= min_new;
        max_reg <= max_new;
      end
    end
  end

  assign min_out = min_reg;
  assign max_out = max_reg;
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_ro_meter_multich.sv
// Testbench for ro_meter_multich: randomized window edge counts, checked
// against a reference model of the batch sum, average, overflow and extremes.

module tb_ro_meter_multich;

  localparam int CHANNELS    = 3;
  localparam int CNT_W       = 5;
  localparam int WINDOW      = 256;
  localparam int WARMUP      = 16;
  localparam int LOG2_AVG    = 3;
  localparam int SYNC_STAGES = 2;
  localparam int NSAMP       = 1 << LOG2_AVG;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int LATENCY     = 1 + WARMUP + NSAMP * (WINDOW + 1);
`ifdef ROMETER_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic                clk1 = 1'b0;
  logic                rst_n;
  logic [CHANNELS-1:0] osc_in;
  logic [CHANNELS-1:0] osc_en;
  logic                start;
  logic                abort;
  logic [1:0]          ch_sel;
  logic                busy;
  logic                done;
  logic                err;
  logic                ovf;
  logic [1:0]          result_ch;
  logic [7:0]          sum_out;
  logic [4:0]          avg_out;
  logic [4:0]          min_out;
  logic [4:0]          max_out;

  ro_meter_multich #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .WINDOW(WINDOW), .WARMUP(WARMUP),
    .LOG2_AVG(LOG2_AVG), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .osc_in(osc_in), .osc_en(osc_en),
    .start(start), .abort(abort), .ch_sel(ch_sel), .busy(busy), .done(done),
    .err(err), .ovf(ovf), .result_ch(result_ch), .sum_out(sum_out),
    .avg_out(avg_out), .min_out(min_out), .max_out(max_out)
  );

  always #5 clk1 = ~clk1;

  int unsigned cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // Stimulus plan: mode 0 = quiet, 1 = free-running square, 2 = n_win[k] pulses per gate.
  int mode = 0;
  int period = 16;
  int sel_ch = 0;
  int t0 = 0;
  int n_win [NSAMP];

  // Reference copy of the held result outputs.
  int last_sum = 0, last_ch = 0, last_ovf = 0, last_min = 0, last_max = 0;

  int n_cmp = 0;
  int n_bad = 0;

  // Oscillator bank: noise on unselected channels and the planned waveform
  // on the selected one. Pulses are 3 cycles high and 3 cycles low, starting
  // well inside each gate window.
  always @(negedge clk1) begin : osc_drive
    logic [CHANNELS-1:0] v;
    logic b;
    int rel, k, off;
    v = CHANNELS'($urandom);
    b = 1'b0;
    rel = int'(cyc) - t0 - 1 - WARMUP;
    if (mode == 1) begin
      b = ((cyc % period) < (period / 2));
    end else if (mode == 2 && rel >= 0) begin
      k = rel / (WINDOW + 1);
      off = rel % (WINDOW + 1);
      if (k < NSAMP && off >= 20 && off < 20 + 6 * n_win[k] && ((off - 20) % 6) < 3) b = 1'b1;
    end
    v[sel_ch] = b;
    osc_in = v;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present start for one cycle. This returns at the first negedge after
  // start has been sampled (cycle 1).
  task automatic start_batch(input int ch, input bit with_abort);
    t0 = int'(cyc);
    start = 1'b1;
    ch_sel = 2'(ch);
    abort = with_abort;
    @(negedge clk1);
    start = 1'b0;
    abort = 1'b0;
    ch_sel = 2'($urandom);
  endtask

  task automatic wait_done(input int lat_in, output int lat_out);
    lat_out = lat_in;
    while (done !== 1'b1 && lat_out < LATENCY + 50) begin
      @(negedge clk1);
      lat_out++;
    end
  endtask

  // One complete batch: plan the window counts, model the result, run, and compare.
  task automatic run_batch(input int ch, input int md, input int lo, input int hi,
                           input bit with_abort, input int dup_at);
    int c, lat, s, mn, mx, ov;
    s = 0; mn = CNT_MAX + 1; mx = -1; ov = 0;
    for (int k = 0; k < NSAMP; k++) begin
      n_win[k] = $urandom_range(hi, lo);
      if (n_win[k] == CNT_MAX) n_win[k] = CNT_MAX - 1;
      c = (md == 1) ? WINDOW / period : n_win[k];
      if (c > CNT_MAX) begin
        c = CNT_MAX;
        ov = 1;
      end
      s += c;
      if (c < mn) mn = c;
      if (c > mx) mx = c;
    end
    mode = md;
    sel_ch = ch;
    start_batch(ch, with_abort);
    lat = 1;
    repeat (8) begin
      @(negedge clk1);
      lat++;
    end
    check("osc_en_onehot", osc_en, 64'(1 << ch));
    check("busy_running", busy, 1);
    if (dup_at > 0) begin
      while (lat < dup_at) begin
        @(negedge clk1);
        lat++;
      end
      start = 1'b1;
      ch_sel = 2'((ch + 1) % CHANNELS);
      @(negedge clk1);
      lat++;
      start = 1'b0;
    end
    wait_done(lat, lat);
    check("latency", lat, LATENCY);
    check("done", done, 1);
    check("err_clear", err, 0);
    check("sum_out", sum_out, s);
    check("avg_out", avg_out, s >> LOG2_AVG);
    check("ovf", ovf, ov);
    check("result_ch", result_ch, ch);
    check("min_out", min_out, MINMAX ? mn : 0);
    check("max_out", max_out, MINMAX ? mx : 0);
    last_sum = s; last_ch = ch; last_ovf = ov;
    last_min = MINMAX ? mn : 0;
    last_max = MINMAX ? mx : 0;
    $display("batch ch=%0d mode=%0d sum=%0d avg=%0d ovf=%0d latency=%0d", ch, md, sum_out, avg_out, ovf, lat);
    @(negedge clk1);
    check("done_pulse_end", done, 0);
    check("idle_after_done", busy, 0);
    check("sum_hold", sum_out, last_sum);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_sum"}, sum_out, last_sum);
    check({tag, "_ch"}, result_ch, last_ch);
    check({tag, "_ovf"}, ovf, last_ovf);
    check({tag, "_min"}, min_out, last_min);
    check({tag, "_max"}, max_out, last_max);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ch_sel = '0;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_osc_en", osc_en, 0);
    check("rst_avg", avg_out, 0);
    check_held("rst");

    // Square wave with a period of 16: 16 edges in every window.
    period = 16;
    run_batch(2, 1, 0, 0, 1'b0, 0);

    // Random pulse counts, then counts that all saturate.
    run_batch(1, 2, 0, 30, 1'b0, 0);
    run_batch(0, 2, 32, 36, 1'b0, 0);

    // Invalid channel: a one-cycle DONE with err, and the results held.
    start_batch(3, 1'b0);
    check("err_done", done, 1);
    check("err_flag", err, 1);
    check("err_busy", busy, 1);
    check("err_osc_en", osc_en, 0);
    check_held("err_hold");
    $display("reject ch=3 done=%0d err=%0d", done, err);
    @(negedge clk1);
    check("err_busy_end", busy, 0);
    check("err_done_end", done, 0);
    check("err_flag_end", err, 0);

    // start and abort together in IDLE: start wins.
    run_batch(2, 2, 0, 30, 1'b1, 0);

    // abort in the gate of sample 3: no done, and the results held.
    for (int k = 0; k < NSAMP; k++) n_win[k] = $urandom_range(30, 0);
    mode = 2; sel_ch = 1;
    start_batch(1, 1'b0);
    repeat (WARMUP + 3 * (WINDOW + 1) + 100) @(negedge clk1);
    abort = 1'b1;
    @(negedge clk1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_osc_en", osc_en, 0);
    check("abort_done", done, 0);
    check_held("abort_hold");
    seen = 0;
    repeat (LATENCY) begin
      @(negedge clk1);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    $display("abort ch=1 busy=%0d sum=%0d", busy, sum_out);
    run_batch(1, 2, 0, 30, 1'b0, 0);

    // A second start during the gate is ignored; latency and channel are unchanged.
    run_batch(2, 2, 5, 30, 1'b0, 500);

    // Reset in mid-batch: reset values, and no done afterwards.
    for (int k = 0; k < NSAMP; k++) n_win[k] = $urandom_range(30, 0);
    mode = 2; sel_ch = 2;
    start_batch(2, 1'b0);
    repeat (700) @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    last_sum = 0; last_ch = 0; last_ovf = 0; last_min = 0; last_max = 0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_osc_en", osc_en, 0);
    check("mrst_avg", avg_out, 0);
    check_held("mrst");
    seen = 0;
    repeat (LATENCY) begin
      @(negedge clk1);
      if (done === 1'b1) seen++;
    end
    check("mrst_no_done", seen, 0);
    $display("midreset busy=%0d sum=%0d", busy, sum_out);

    // Recovery with a mix of saturating and non-saturating windows.
    run_batch(0, 2, 0, 36, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
